// File: rtl/vend_txn_fsm.sv
// rtl/vend_txn_fsm.sv - vending transaction controller: key event conditioning plus
// slot/quantity/payment sequencing with dispense, refund and stock-error strobes.
`timescale 1ns/1ps
module vend_txn_fsm #(
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 500_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  key_val,
  input  logic        key_ensure,
  input  logic        key_back,
  input  logic [20:0] stock,
  output logic [2:0]  state,
  output logic [2:0]  slot,
  output logic [2:0]  qty,
  output logic [5:0]  due,
  output logic [5:0]  paid,
  output logic [5:0]  change,
  output logic        dispense_pulse,
  output logic        refund_pulse,
  output logic        err_stock
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_QTY    = 3'd1;
  localparam logic [2:0] S_PAY    = 3'd2;
  localparam logic [2:0] S_DISP   = 3'd3;
  localparam logic [2:0] S_REFUND = 3'd4;

  logic [4:0]    sync1, sync2, hist;
  logic [2:0]    hist2;
  logic [TW-1:0] tmo;
  logic [2:0]    dig, stk_dig, stk_slot;
  logic          dig_ev, ens_ev, back_ev, tmo_hit, accepted, go_idle;
  logic [2:0]    stk_arr [8];
  logic [6:0]    psum;

  logic [2:0] n_state, n_slot, n_qty;
  logic [5:0] n_due, n_paid, n_change;
  logic       n_disp, n_ref, n_err;

  // Slot 0 means "no slot" and always reads as empty.
  assign stk_arr[0] = 3'd0;
  assign stk_arr[1] = stock[2:0];
  assign stk_arr[2] = stock[5:3];
  assign stk_arr[3] = stock[8:6];
  assign stk_arr[4] = stock[11:9];
  assign stk_arr[5] = stock[14:12];
  assign stk_arr[6] = stock[17:15];
  assign stk_arr[7] = stock[20:18];

  // A digit counts once: stable for two samples after a zero sample.
  assign dig      = sync2[2:0];
  assign dig_ev   = (dig != 3'd0) && (dig == hist[2:0]) && (hist2 == 3'd0);
  assign ens_ev   = sync2[3] & ~hist[3];
  assign back_ev  = sync2[4] & ~hist[4];
  assign stk_dig  = stk_arr[dig];
  assign stk_slot = stk_arr[slot];
  assign tmo_hit  = ((state == S_QTY) || (state == S_PAY)) && (tmo == TMO_LAST);
  assign psum     = {1'b0, paid} + {4'd0, dig};

  always_comb begin
    n_state  = state;
    n_slot   = slot;
    n_qty    = qty;
    n_due    = due;
    n_paid   = paid;
    n_change = change;
    n_disp   = 1'b0;
    n_ref    = 1'b0;
    n_err    = 1'b0;
    accepted = 1'b0;
    go_idle  = 1'b0;
    case (state)
      S_IDLE: begin
        if (dig_ev) begin
          if (stk_dig != 3'd0) begin
            n_state  = S_QTY;
            n_slot   = dig;
            n_qty    = 3'd0;
            n_paid   = 6'd0;
            accepted = 1'b1;
          end else begin
            n_err = 1'b1;
          end
        end
      end
      S_QTY: begin
        if (back_ev) begin
          accepted = 1'b1;
          go_idle  = 1'b1;
        end else if (ens_ev && (qty != 3'd0)) begin
          accepted = 1'b1;
          n_due    = 6'(int'(qty) * PRICE);
          n_state  = S_PAY;
        end else if (dig_ev) begin
          if (dig <= stk_slot) begin
            n_qty    = dig;
            accepted = 1'b1;
          end else begin
            n_err = 1'b1;
          end
        end
        if (tmo_hit && !accepted) go_idle = 1'b1;
      end
      S_PAY: begin
        // Back and timeout outrank completion; a coin arriving with the timeout wins.
        if (back_ev || (tmo_hit && !dig_ev)) begin
          accepted = back_ev;
          if (paid != 6'd0) begin
            n_state = S_REFUND;
            n_ref   = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end else if (paid >= due) begin
          n_state  = S_DISP;
          n_disp   = 1'b1;
          n_change = paid - due;
        end else if (dig_ev) begin
          n_paid   = psum[6] ? 6'd63 : psum[5:0];
          accepted = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      n_state  = S_IDLE;
      n_slot   = 3'd0;
      n_qty    = 3'd0;
      n_due    = 6'd0;
      n_paid   = 6'd0;
      n_change = 6'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1          <= '0;
      sync2          <= '0;
      hist           <= '0;
      hist2          <= '0;
      tmo            <= '0;
      state          <= S_IDLE;
      slot           <= '0;
      qty            <= '0;
      due            <= '0;
      paid           <= '0;
      change         <= '0;
      dispense_pulse <= 1'b0;
      refund_pulse   <= 1'b0;
      err_stock      <= 1'b0;
    end else begin
      sync1          <= {key_back, key_ensure, key_val};
      sync2          <= sync1;
      hist           <= sync2;
      hist2          <= hist[2:0];
      state          <= n_state;
      slot           <= n_slot;
      qty            <= n_qty;
      due            <= n_due;
      paid           <= n_paid;
      change         <= n_change;
      dispense_pulse <= n_disp;
      refund_pulse   <= n_ref;
      err_stock      <= n_err;
      if (((state != S_QTY) && (state != S_PAY)) || accepted || (n_state != state))
        tmo <= '0;
      else
        tmo <= tmo + TW'(1);
    end
  end

endmodule

// File: tb/tb_vend_txn_fsm.sv
// tb/tb_vend_txn_fsm.sv - bench for vend_txn_fsm: two instances (PRICE 3 and 9) checked
// every cycle against an event-scheduled purchase model, plus literal expectations.
`timescale 1ns/1ps
module tb_vend_txn_fsm;

  localparam int P0 = 3, T0 = 100;
  localparam int P1 = 9, T1 = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  kv [2];
  logic        ke [2];
  logic        kb [2];
  logic [20:0] stock;
  logic [2:0]  st [2], sl [2], q [2];
  logic [5:0]  du [2], pd [2], ch [2];
  logic        dp [2], rf [2], er [2];

  vend_txn_fsm #(.PRICE(P0), .TIMEOUT(T0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .key_val(kv[0]), .key_ensure(ke[0]), .key_back(kb[0]),
    .stock(stock), .state(st[0]), .slot(sl[0]), .qty(q[0]), .due(du[0]), .paid(pd[0]),
    .change(ch[0]), .dispense_pulse(dp[0]), .refund_pulse(rf[0]), .err_stock(er[0]));

  vend_txn_fsm #(.PRICE(P1), .TIMEOUT(T1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .key_val(kv[1]), .key_ensure(ke[1]), .key_back(kb[1]),
    .stock(stock), .state(st[1]), .slot(sl[1]), .qty(q[1]), .due(du[1]), .paid(pd[1]),
    .change(ch[1]), .dispense_pulse(dp[1]), .refund_pulse(rf[1]), .err_stock(er[1]));

  int total = 0, bad = 0, cyc = 0, last_ev = 0;

  typedef struct {int inst; int at; int kind; int val;} ev_t;
  ev_t evq[$];

  int price [2] = '{P0, P1};
  int tlim  [2] = '{T0, T1};
  int m_st [2], m_sl [2], m_q [2], m_du [2], m_pd [2], m_ch [2], m_last [2];
  bit m_dp [2], m_rf [2], m_er [2];
  int disp_n [2], ref_n [2], err_n [2];
  int d_slot [2], d_qty [2], d_chg [2], d_paid [2], r_paid [2], r_cyc [2];

  function automatic int stk(int s);
    if (s == 0) return 0;
    return int'((stock >> (3 * (s - 1))) & 21'd7);
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_clr(int i);
    m_st[i] = 0; m_sl[i] = 0; m_q[i] = 0; m_du[i] = 0; m_pd[i] = 0; m_ch[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_clr(i);
      m_dp[i] = 0; m_rf[i] = 0; m_er[i] = 0; m_last[i] = 0;
    end
    evq.delete();
  endtask

  // Purchase rules applied at clock edge k, driven by the events scheduled for that edge.
  task automatic model_step(int i, int k);
    int dg = 0;
    bit en = 0, bk = 0, acc = 0, tmo;
    int ost;
    foreach (evq[j]) begin
      if (evq[j].inst == i && evq[j].at == k) begin
        if (evq[j].kind == 0) dg = evq[j].val;
        else if (evq[j].kind == 1) en = 1;
        else bk = 1;
      end
    end
    ost = m_st[i];
    tmo = (ost == 1 || ost == 2) && (k - m_last[i] >= tlim[i]);
    m_dp[i] = 0; m_rf[i] = 0; m_er[i] = 0;
    case (ost)
      0: if (dg != 0) begin
           if (stk(dg) != 0) begin
             m_st[i] = 1; m_sl[i] = dg; m_q[i] = 0; m_pd[i] = 0; acc = 1;
           end else m_er[i] = 1;
         end
      1: begin
           if (bk) begin acc = 1; model_clr(i); end
           else if (en && m_q[i] != 0) begin acc = 1; m_du[i] = m_q[i] * price[i]; m_st[i] = 2; end
           else if (dg != 0) begin
             if (dg <= stk(m_sl[i])) begin m_q[i] = dg; acc = 1; end
             else m_er[i] = 1;
           end
           if (!acc && tmo) model_clr(i);
         end
      2: begin
           if (bk || (tmo && dg == 0)) begin
             acc = bk;
             if (m_pd[i] != 0) begin m_st[i] = 4; m_rf[i] = 1; end
             else model_clr(i);
           end else if (m_pd[i] >= m_du[i]) begin
             m_st[i] = 3; m_dp[i] = 1; m_ch[i] = m_pd[i] - m_du[i];
           end else if (dg != 0) begin
             m_pd[i] = (m_pd[i] + dg > 63) ? 63 : m_pd[i] + dg;
             acc = 1;
           end
         end
      default: model_clr(i);
    endcase
    if (acc || m_st[i] != ost) m_last[i] = k;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n) for (int i = 0; i < 2; i++) model_step(i, cyc);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (int'(st[i]) != m_st[i] || int'(sl[i]) != m_sl[i] || int'(q[i]) != m_q[i] ||
            int'(du[i]) != m_du[i] || int'(pd[i]) != m_pd[i] || int'(ch[i]) != m_ch[i] ||
            dp[i] != m_dp[i] || rf[i] != m_rf[i] || er[i] != m_er[i]) begin
          bad++;
          $display("FAIL model_cmp inst=%0d cyc=%0d actual st=%0d slot=%0d qty=%0d due=%0d paid=%0d chg=%0d d/r/e=%0d%0d%0d required st=%0d slot=%0d qty=%0d due=%0d paid=%0d chg=%0d d/r/e=%0d%0d%0d",
                   i, cyc, st[i], sl[i], q[i], du[i], pd[i], ch[i], dp[i], rf[i], er[i],
                   m_st[i], m_sl[i], m_q[i], m_du[i], m_pd[i], m_ch[i], m_dp[i], m_rf[i], m_er[i]);
        end
        if (dp[i]) begin
          disp_n[i]++; d_slot[i] = sl[i]; d_qty[i] = q[i]; d_chg[i] = ch[i]; d_paid[i] = pd[i];
        end
        if (rf[i]) begin ref_n[i]++; r_paid[i] = pd[i]; r_cyc[i] = cyc; end
        if (er[i]) err_n[i]++;
      end
    end
  end

  task automatic push(int i, int at, int kind, int val);
    ev_t e;
    e.inst = i; e.at = at; e.kind = kind; e.val = val;
    evq.push_back(e);
  endtask

  // Digits register at the fourth edge after the drive, ensure/back at the third.
  task automatic dig(int i, int d, int hold = 3);
    @(negedge clk);
    kv[i] = 3'(d);
    if (d != 0) begin push(i, cyc + 4, 0, d); last_ev = cyc + 4; end
    repeat (hold) @(negedge clk);
    kv[i] = 3'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ens(int i);
    @(negedge clk); ke[i] = 1'b1; push(i, cyc + 3, 1, 0);
    repeat (3) @(negedge clk); ke[i] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic back(int i);
    @(negedge clk); kb[i] = 1'b1; push(i, cyc + 3, 2, 0);
    repeat (3) @(negedge clk); kb[i] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic glitch(int i);
    @(negedge clk); kv[i] = 3'd6;
    @(negedge clk); kv[i] = 3'd0;
    repeat (6) @(negedge clk);
  endtask

  function automatic int outs(int i);
    return int'({st[i], sl[i], q[i], du[i], pd[i], ch[i], dp[i], rf[i], er[i]});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int e0, r0, n0, t_ev;
    for (int i = 0; i < 2; i++) begin kv[i] = 3'd0; ke[i] = 1'b0; kb[i] = 1'b0; end
    stock = {3'd7, 3'd4, 3'd0, 3'd4, 3'd5, 3'd1, 3'd4};
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outs_0", outs(0), 0);
    chk("reset_outs_1", outs(1), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // happy path, PRICE 3
    dig(0, 3); dig(0, 2); ens(0);
    chk("due_6", du[0], 6);
    chk("state_pay", st[0], 2);
    dig(0, 4);
    chk("paid_4", pd[0], 4);
    dig(0, 5);
    chk("disp_count", disp_n[0], 1);
    chk("disp_slot", d_slot[0], 3);
    chk("disp_qty", d_qty[0], 2);
    chk("disp_change", d_chg[0], 3);
    chk("disp_paid", d_paid[0], 9);
    chk("idle_fields", outs(0), 0);

    // empty slot and over-quantity
    e0 = err_n[0];
    dig(0, 5);
    chk("empty_stays_idle", st[0], 0);
    dig(0, 2);
    chk("slot2_qty_state", st[0], 1);
    dig(0, 4);
    chk("err_twice", err_n[0] - e0, 2);
    chk("qty_unchanged", q[0], 0);
    back(0);
    chk("back_qty_idle", st[0], 0);

    // refund with paid=2, then back with paid=0
    r0 = ref_n[0];
    dig(0, 3); dig(0, 1); ens(0); dig(0, 2); back(0);
    chk("refund_count", ref_n[0] - r0, 1);
    chk("refund_paid", r_paid[0], 2);
    chk("refund_then_paid0", pd[0], 0);
    dig(0, 3); dig(0, 1); ens(0); back(0);
    chk("back_paid0_nopulse", ref_n[0] - r0, 1);
    chk("back_paid0_idle", st[0], 0);

    // held key and glitch, long-timeout instance
    dig(1, 3); dig(1, 2); ens(1);
    chk("due_18", du[1], 18);
    dig(1, 4, 10000);
    chk("held_paid_4", pd[1], 4);
    glitch(1);
    chk("glitch_paid_4", pd[1], 4);
    back(1);
    chk("held_refund_paid", r_paid[1], 4);

    // timeout in PAY, then in QTY
    dig(0, 3); dig(0, 1); ens(0); dig(0, 1);
    t_ev = last_ev;
    r0 = ref_n[0];
    repeat (150) @(negedge clk);
    chk("tmo_refund_count", ref_n[0] - r0, 1);
    chk("tmo_latency", r_cyc[0] - t_ev, 100);
    chk("tmo_refund_paid", r_paid[0], 1);
    chk("tmo_idle", st[0], 0);
    dig(0, 3);
    chk("qty_entered", st[0], 1);
    repeat (150) @(negedge clk);
    chk("qty_tmo_idle", outs(0), 0);
    chk("qty_tmo_nopulse", ref_n[0] - r0, 1);

    // saturation, PRICE 9, qty 7
    n0 = disp_n[1];
    dig(1, 7); dig(1, 7); ens(1);
    chk("due_63", du[1], 63);
    dig(1, 5);
    for (int j = 0; j < 8; j++) dig(1, 7);
    chk("paid_61", pd[1], 61);
    dig(1, 7);
    chk("sat_disp_count", disp_n[1] - n0, 1);
    chk("sat_paid", d_paid[1], 63);
    chk("sat_change", d_chg[1], 0);

    // async reset mid-PAY
    dig(0, 3); dig(0, 2); ens(0); dig(0, 1);
    chk("pre_rst_paid", pd[0], 1);
    n0 = disp_n[0]; r0 = ref_n[0];
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", outs(0), 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_pulse", (disp_n[0] - n0) + (ref_n[0] - r0), 0);
    chk("rst_idle", st[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
